// File: rtl/arb_rr_pkt_lock.sv
// rtl/arb_rr_pkt_lock.sv - round-robin packet arbiter with per-packet grant lock and beat watchdog
module arb_rr_pkt_lock #(
    parameter int REQ_WIDTH  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BEATS  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [REQ_WIDTH-1:0]            req_valid,
    input  logic [REQ_WIDTH-1:0]            req_last,
    input  logic [REQ_WIDTH*DATA_WIDTH-1:0] req_data,
    output logic [REQ_WIDTH-1:0]            req_ready,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_last,
    input  logic                            out_ready,
    output logic [REQ_WIDTH-1:0]            gnt,
    output logic                            busy,
    output logic                            wdog_err
);

    localparam int PW = $clog2(REQ_WIDTH);
    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [REQ_WIDTH-1:0] gnt_q, gnt_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 wdog_q, wdog_d;

    logic [PW-1:0]        win_idx;
    logic [PW-1:0]        own_idx;
    logic [PW-1:0]        ptr_nxt;
    logic                 xfer;

    // First requesting source scanning upward from ptr, wrapping.
    always_comb begin
        win_idx = '0;
        for (int i = REQ_WIDTH - 1; i >= 0; i--) begin
            logic [PW-1:0] cand;
            cand = PW'((int'(ptr_q) + i) % REQ_WIDTH);
            if (req_valid[cand]) begin
                win_idx = cand;
            end
        end
    end

    always_comb begin
        own_idx = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (gnt_q[i]) begin
                own_idx = PW'(i);
            end
        end
    end

    assign ptr_nxt = (own_idx == PW'(REQ_WIDTH - 1)) ? '0 : own_idx + PW'(1);

    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        if (state_q == BUSY) begin
            out_valid          = req_valid[own_idx];
            out_data           = req_data[int'(own_idx)*DATA_WIDTH +: DATA_WIDTH];
            out_last           = req_last[own_idx];
            req_ready[own_idx] = out_ready;
        end
    end

    assign xfer     = out_valid && out_ready;
    assign gnt      = gnt_q;
    assign busy     = (state_q == BUSY);
    assign wdog_err = wdog_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wdog_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    state_d        = BUSY;
                    cnt_d          = '0;
                end
            end
            BUSY: begin
                if (xfer) begin
                    // A last beat always wins over the watchdog on the same beat.
                    if (out_last || (cnt_q == CW'(MAX_BEATS - 1))) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        ptr_d   = ptr_nxt;
                        cnt_d   = '0;
                        wdog_d  = !out_last;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            wdog_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_arb_rr_pkt_lock.sv
// tb/tb_arb_rr_pkt_lock.sv - table-driven bench for arb_rr_pkt_lock
module tb_arb_rr_pkt_lock;

    localparam int RW = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [RW-1:0] req_valid, req_last, req_ready, gnt;
    logic [RW*DW-1:0] req_data;
    logic          out_valid, out_last, out_ready, busy, wdog_err;
    logic [DW-1:0] out_data;

    arb_rr_pkt_lock #(.REQ_WIDTH(RW), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready),
        .gnt(gnt), .busy(busy), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [RW-1:0] rv;
        logic [RW-1:0] rl;
        logic          ordy;
        logic [RW-1:0] gnt;
        logic [RW-1:0] rr;
        logic          ov;
        logic          ol;
        logic          bsy;
        logic          wd;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input logic rst, input logic [RW-1:0] rv, input logic [RW-1:0] rl,
                       input logic ordy, input logic [RW-1:0] g, input logic [RW-1:0] rr,
                       input logic ov, input logic ol, input logic bsy, input logic wd);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rl = rl; v.ordy = ordy; v.gnt = g; v.rr = rr;
        v.ov = ov; v.ol = ol; v.bsy = bsy; v.wd = wd;
        tbl.push_back(v);
    endtask

    task automatic idle(input logic [RW-1:0] rv, input logic wd);
        add(1'b0, rv, '0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, wd);
    endtask

    task automatic bz(input logic [RW-1:0] rv, input logic [RW-1:0] rl, input logic ordy,
                      input logic [RW-1:0] g, input logic ov, input logic ol);
        add(1'b0, rv, rl, ordy, g, ordy ? g : '0, ov, ol, 1'b1, 1'b0);
    endtask

    function automatic logic [DW-1:0] src_data(input logic [RW-1:0] g);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < RW; i++) begin
            if (g[i]) d = DW'(8'h10 * i + 8'h05);
        end
        return d;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < RW; i++) req_data[i*DW +: DW] = DW'(8'h10 * i + 8'h05);

        // Reset state and alternating sources 1 and 3.
        add(1'b1, '0, '0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4'b1010, 1'b0); bz(4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1);
        idle(4'b1010, 1'b0); bz(4'b1010, 4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1);
        idle(4'b1010, 1'b0); bz(4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1);

        // All sources with 2-beat packets: order 0,1,2,3,0.
        add(1'b1, '0, '0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            idle(4'b1111, 1'b0);
            bz(4'b1111, 4'b0000, 1'b1, RW'(1 << (k % RW)), 1'b1, 1'b0);
            bz(4'b1111, 4'b1111, 1'b1, RW'(1 << (k % RW)), 1'b1, 1'b1);
        end

        // Owner 2 drops valid mid-packet; lock holds, source 0 waits.
        idle(4'b0101, 1'b0);
        for (int k = 0; k < 3; k++) bz(4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) bz(4'b0001, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0);
        bz(4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1);
        idle(4'b0001, 1'b0);
        bz(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1);

        // Downstream stall for 4 cycles.
        idle(4'b0010, 1'b0);
        for (int k = 0; k < 4; k++) bz(4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b0);
        bz(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1);

        // Runaway packet from source 1, then ptr=2 makes source 0 beat source 1.
        idle(4'b0010, 1'b0);
        for (int k = 0; k < MB; k++) bz(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0);
        idle(4'b0011, 1'b1);
        bz(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1);

        // Exactly MAX_BEATS beats with last on the final one: no watchdog.
        idle(4'b0010, 1'b0);
        for (int k = 0; k < MB - 1; k++) bz(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 1'b0);
        bz(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1);
        idle(4'b0000, 1'b0);

        // Reset mid-packet from owner 3; ptr returns to 0.
        idle(4'b1000, 1'b0);
        bz(4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0);
        bz(4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0);
        add(1'b1, 4'b1001, '0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        bz(4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b1, 1'b1);
        idle(4'b0000, 1'b0);

        foreach (tbl[r]) begin
            @(negedge clk);
            req_valid = tbl[r].rv;
            req_last  = tbl[r].rl;
            out_ready = tbl[r].ordy;
            if (tbl[r].rst) rst_n = 1'b0;
            #1;
            chk("gnt",       r, 32'(gnt),       32'(tbl[r].gnt));
            chk("busy",      r, 32'(busy),      32'(tbl[r].bsy));
            chk("wdog_err",  r, 32'(wdog_err),  32'(tbl[r].wd));
            chk("out_valid", r, 32'(out_valid), 32'(tbl[r].ov));
            chk("req_ready", r, 32'(req_ready), 32'(tbl[r].rr));
            if (tbl[r].bsy) begin
                chk("out_last", r, 32'(out_last), 32'(tbl[r].ol));
                chk("out_data", r, 32'(out_data), 32'(src_data(tbl[r].gnt)));
            end
            if (tbl[r].rst) begin
                #1;
                rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
